// File: rtl/mac_seq_ctrl_if.sv
// Operand-pair input stream and result-byte output stream of the MAC sequencer.
// The slave modport is the sequencer side; the master modport is the feeding/draining side.
interface mac_seq_ctrl_if #(
    parameter int IN_W = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_a;
    logic [IN_W-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic            out_last;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences one shared MAC unit through a COUNT-pair dot product, then drains the
// accumulator LS-byte first. All outputs come straight from registers.
module mac_seq_ctrl #(
    parameter int COUNT = 8,
    parameter int IN_W  = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    mac_seq_ctrl_if.slave    bus,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [IN_W-1:0]  mac_a,
    output logic [IN_W-1:0]  mac_b,
    input  logic [ACC_W-1:0] mac_acc,
    output logic             done
);
    localparam int OUT_BYTES = (ACC_W + 7) / 8;
    localparam int RES_W     = OUT_BYTES * 8;
    localparam int CNT_W     = $clog2(COUNT + 1);
    localparam int IDX_W     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_SETTLE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_pair_cnt;
    logic [IDX_W-1:0] r_byte_idx;
    logic [RES_W-1:0] r_result;
    logic             r_settle;
    logic             r_busy;
    logic             r_in_ready;
    logic             r_mac_clr;
    logic             r_mac_en;
    logic [IN_W-1:0]  r_mac_a;
    logic [IN_W-1:0]  r_mac_b;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_last;
    logic             r_done;

    logic             w_in_hs;
    logic [IDX_W-1:0] w_next_idx;
    logic [7:0]       w_next_byte;
    logic [RES_W-1:0] w_acc_ext;

    assign w_in_hs     = bus.in_valid & r_in_ready;
    assign w_next_idx  = r_byte_idx + 1'b1;
    assign w_next_byte = 8'(r_result >> {w_next_idx, 3'b000});
    assign w_acc_ext   = RES_W'(mac_acc);

    // NOTE: state lives in one clocked block with non-blocking assignments only, so every
    // register sees pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pair_cnt  <= '0;
            r_byte_idx  <= '0;
            r_result    <= '0;
            r_settle    <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mac_clr <= 1'b0;
            r_mac_en  <= 1'b0;
            r_done    <= 1'b0;

            // Abort wins over start and handshakes; the MAC is wiped on the way out.
            if (abort && r_state != S_IDLE) begin
                r_state     <= S_IDLE;
                r_pair_cnt  <= '0;
                r_byte_idx  <= '0;
                r_settle    <= 1'b0;
                r_busy      <= 1'b0;
                r_in_ready  <= 1'b0;
                r_mac_clr   <= 1'b1;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_out_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state    <= S_CLEAR;
                            r_busy     <= 1'b1;
                            r_mac_clr  <= 1'b1;
                            r_pair_cnt <= '0;
                        end
                    end

                    S_CLEAR: begin
                        r_state    <= S_ACCUM;
                        r_in_ready <= 1'b1;
                    end

                    S_ACCUM: begin
                        if (w_in_hs) begin
                            r_mac_a    <= bus.in_a;
                            r_mac_b    <= bus.in_b;
                            r_mac_en   <= 1'b1;
                            r_pair_cnt <= r_pair_cnt + 1'b1;
                            if (r_pair_cnt == CNT_W'(COUNT - 1)) begin
                                r_state    <= S_SETTLE;
                                r_in_ready <= 1'b0;
                                r_settle   <= 1'b0;
                            end
                        end
                    end

                    // First cycle carries the final mac_en; the accumulator is final in the second.
                    S_SETTLE: begin
                        if (!r_settle) begin
                            r_settle <= 1'b1;
                        end else begin
                            r_settle    <= 1'b0;
                            r_result    <= w_acc_ext;
                            r_byte_idx  <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_acc_ext[7:0];
                            r_out_last  <= (OUT_BYTES == 1);
                            r_state     <= S_DRAIN;
                        end
                    end

                    S_DRAIN: begin
                        if (bus.out_ready) begin
                            if (r_out_last) begin
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_byte_idx <= w_next_idx;
                                r_out_data <= w_next_byte;
                                r_out_last <= (w_next_idx == IDX_W'(OUT_BYTES - 1));
                            end
                        end
                    end

                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy          = r_busy;
    assign bus.in_ready  = r_in_ready;
    assign mac_clr       = r_mac_clr;
    assign mac_en        = r_mac_en;
    assign mac_a         = r_mac_a;
    assign mac_b         = r_mac_b;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign done          = r_done;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural MAC unit, cycle monitor and directed/random jobs
// whose expected bytes come from a plain dot-product reference.
module tb_mac_seq_ctrl;
    localparam int COUNT     = 8;
    localparam int IN_W      = 8;
    localparam int ACC_W     = 20;
    localparam int OUT_BYTES = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic             mac_clr;
    logic             mac_en;
    logic [IN_W-1:0]  mac_a;
    logic [IN_W-1:0]  mac_b;
    logic [ACC_W-1:0] mac_acc;
    logic             done;

    mac_seq_ctrl_if #(.IN_W(IN_W)) bus ();

    mac_seq_ctrl #(.COUNT(COUNT), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .busy    (busy),
        .bus     (bus),
        .mac_clr (mac_clr),
        .mac_en  (mac_en),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_acc (mac_acc),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Behavioural MAC unit: clear beats enable, result visible after the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mac_acc <= '0;
        else if (mac_clr) mac_acc <= '0;
        else if (mac_en)  mac_acc <= mac_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle monitor: samples on the falling edge, mid-cycle.
    int         cyc = 0;
    int         done_cnt = 0;
    int         en_cnt = 0;
    int         clr_cnt = 0;
    int         first_valid_cyc = 0;
    logic [7:0] got_bytes[$];
    logic       got_last[$];
    logic       p_hs, p_stall, p_last_acc, p_valid, p_lastflag;
    logic [7:0] p_a, p_b, p_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_hs       <= 1'b0;
            p_stall    <= 1'b0;
            p_last_acc <= 1'b0;
            p_valid    <= 1'b0;
            p_lastflag <= 1'b0;
            p_a        <= '0;
            p_b        <= '0;
            p_data     <= '0;
        end else begin
            check("mac_en_after_handshake", mac_en, p_hs);
            if (p_hs) begin
                check("mac_a_registered", mac_a, p_a);
                check("mac_b_registered", mac_b, p_b);
            end
            check("done_after_last_byte", done, p_last_acc);
            if (p_stall) begin
                check("stall_valid_held", bus.out_valid, 1);
                check("stall_data_held", bus.out_data, p_data);
                check("stall_last_held", bus.out_last, p_lastflag);
            end
            if (bus.out_valid) check("busy_while_draining", busy, 1);
            if (bus.out_valid && !p_valid) first_valid_cyc <= cyc;
            if (done)    done_cnt <= done_cnt + 1;
            if (mac_en)  en_cnt   <= en_cnt + 1;
            if (mac_clr) clr_cnt  <= clr_cnt + 1;
            if (bus.out_valid && bus.out_ready && !abort) begin
                got_bytes.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
            end
            p_hs       <= bus.in_valid && bus.in_ready && !abort;
            p_a        <= bus.in_a;
            p_b        <= bus.in_b;
            p_stall    <= bus.out_valid && !bus.out_ready && !abort;
            p_last_acc <= bus.out_valid && bus.out_ready && bus.out_last && !abort;
            p_valid    <= bus.out_valid;
            p_data     <= bus.out_data;
            p_lastflag <= bus.out_last;
        end
    end

    // Reference: the dot product of the job's pairs, truncated to the accumulator width.
    logic [7:0] pa[COUNT];
    logic [7:0] pb[COUNT];

    function automatic logic [23:0] ref_result();
        longint s = 0;
        for (int i = 0; i < COUNT; i++) s += longint'(pa[i]) * longint'(pb[i]);
        s = s & ((longint'(1) << ACC_W) - 1);
        return 24'(s);
    endfunction

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        bit acc = 1'b0;
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid = 1'b0;
        check("in_handshake", acc, 1);
    endtask

    task automatic wait_out_valid();
        int t = 0;
        while (!bus.out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("out_valid_seen", bus.out_valid, 1);
    endtask

    // gap/stall < 0 picks a random 0..3 per pair/byte.
    task automatic run_job(input int gap, input int stall, input bit poke_start, input bit chk_lat);
        int          en0 = en_cnt;
        int          clr0 = clr_cnt;
        int          dn0 = done_cnt;
        int          st_cyc;
        int          g;
        int          s;
        logic [23:0] exp_res;
        exp_res = ref_result();
        got_bytes.delete();
        got_last.delete();
        start = 1'b1;
        st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < COUNT; i++) begin
            send_pair(pa[i], pb[i]);
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            repeat (g) begin @(posedge clk); #1; end
            if (poke_start && i == 1) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        for (int j = 0; j < OUT_BYTES; j++) begin
            wait_out_valid();
            s = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
            repeat (s) begin @(posedge clk); #1; end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
        repeat (2) begin @(posedge clk); #1; end
        if (chk_lat) check("first_out_valid_latency", first_valid_cyc - st_cyc, COUNT + 4);
        check("done_pulses", done_cnt - dn0, 1);
        check("mac_en_pulses", en_cnt - en0, COUNT);
        check("mac_clr_pulses", clr_cnt - clr0, 1);
        check("busy_after_job", busy, 0);
        check("byte_count", got_bytes.size(), OUT_BYTES);
        for (int j = 0; j < OUT_BYTES && j < got_bytes.size(); j++) begin
            check($sformatf("byte%0d", j), got_bytes[j], 8'(exp_res >> (8 * j)));
            check($sformatf("last%0d", j), got_last[j], (j == OUT_BYTES - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int clr0;
        int dn0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #2;
        check("reset_outputs", {busy, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last,
                                done, mac_en, mac_clr, mac_a, mac_b}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // (3,3) x8 back-to-back: 0x48, with latency check
        for (int i = 0; i < COUNT; i++) begin pa[i] = 8'd3; pb[i] = 8'd3; end
        run_job(0, 0, 1'b0, 1'b1);

        // (255,255) x8: 0x7F008
        for (int i = 0; i < COUNT; i++) begin pa[i] = 8'd255; pb[i] = 8'd255; end
        run_job(0, 0, 1'b0, 1'b1);

        // (i+1,i+2) with in_valid 1,0,0,1,...: 240
        for (int i = 0; i < COUNT; i++) begin pa[i] = 8'(i + 1); pb[i] = 8'(i + 2); end
        run_job(2, 0, 1'b0, 1'b0);

        // Random operands, 5-cycle backpressure on every byte
        for (int i = 0; i < COUNT; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
        run_job(0, 5, 1'b0, 1'b0);

        // Abort after 4 pairs, with a would-be handshake in the abort cycle
        for (int i = 0; i < COUNT; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
        got_bytes.delete();
        dn0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_pair(pa[i], pb[i]);
        clr0 = clr_cnt;
        bus.in_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort_mac_clr", mac_clr, 1);
        check("abort_busy", busy, 0);
        check("abort_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        repeat (12) begin @(posedge clk); #1; end
        check("abort_no_bytes", got_bytes.size(), 0);
        check("abort_no_done", done_cnt - dn0, 0);
        check("abort_clr_once", clr_cnt - clr0, 1);

        // Next job (1,1) x8 with a start pulse while busy
        for (int i = 0; i < COUNT; i++) begin pa[i] = 8'd1; pb[i] = 8'd1; end
        run_job(0, 0, 1'b1, 1'b0);

        // Reset asserted while byte 1 is on the output
        for (int i = 0; i < COUNT; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < COUNT; i++) send_pair(pa[i], pb[i]);
        wait_out_valid();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("byte1_on_output", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last,
                                      done, mac_en, mac_clr, mac_a, mac_b}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_in_ready_after_reset", bus.in_ready, 0);
            check("idle_busy_after_reset", busy, 0);
        end
        for (int i = 0; i < COUNT; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
        run_job(0, 0, 1'b0, 1'b1);

        // Random jobs: random gaps, stalls, and a start poke while busy
        repeat (3) begin
            for (int i = 0; i < COUNT; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
            run_job(-1, -1, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that feeds one shared MAC unit a COUNT-long dot product and drains the result as bytes.
- Starts a job on `start`; the MAC unit is cleared at the beginning of each job.
- Accepts COUNT operand pairs over a valid/ready handshake.
- Issues one registered MAC enable per accepted pair.
- Captures the accumulator once the last product has settled and streams it out LS-byte first over a valid/ready handshake.
- Sits between the 8-bit pad interface and the 20-bit MAC units in the top level.

Parameters:
COUNT, 8, operand pairs per job (2..255)
IN_W, 8, operand width
ACC_W, 20, MAC accumulator width; OUT_BYTES = ceil(ACC_W/8) (derived localparam, 3 at default)

Ports:
clk  input  1  clock (the codebase's standard clock port name)
rst_n  input  1  asynchronous reset, active-low (the codebase's standard reset port name)
start  input  1  job request pulse; ignored unless IDLE
abort  input  1  synchronous abort, any state
busy  output  1  high in every state except IDLE
in_valid  input  1  operand pair valid
in_ready  output  1  high only in ACCUM
in_a  input  IN_W  operand A
in_b  input  IN_W  operand B
mac_clr  output  1  one-cycle clear to the MAC unit
mac_en  output  1  registered accumulate strobe
mac_a  output  IN_W  registered operand A to the MAC unit
mac_b  output  IN_W  registered operand B to the MAC unit
mac_acc  input  ACC_W  MAC accumulator
out_valid  output  1  result byte valid
out_ready  input  1  result byte accepted
out_data  output  8  result byte
out_last  output  1  high with the final byte
done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, result register 0. mac_clr is not driven by reset; the MAC unit has its own reset.
- MAC contract: mac_clr or mac_en sampled at edge t; mac_acc reflects the update after edge t. mac_clr has priority over mac_en.
- States: IDLE, CLEAR, ACCUM, SETTLE, DRAIN, DONE.
- IDLE:
  - start=1 -> CLEAR.
  - in_valid is ignored and in_ready=0.
- CLEAR:
  - mac_clr=1 for exactly this cycle; pair counter := 0.
  - -> ACCUM.
- ACCUM:
  - in_ready=1; a handshake is in_valid & in_ready.
  - Each handshake registers mac_a/mac_b and sets mac_en=1 for the following cycle only. Otherwise mac_en=0 and mac_a/mac_b hold their last values.
  - Pair counter increments per handshake. On the COUNT-th handshake -> SETTLE.
  - Gaps in in_valid simply stall the job.
- SETTLE:
  - Lasts 2 cycles. Cycle 1 carries the final mac_en; the accumulator is valid after it.
  - The last cycle latches mac_acc, zero-extended to OUT_BYTES*8, into the result register; byte index := 0.
  - -> DRAIN.
- DRAIN:
  - out_valid=1; out_data = result byte[index], LS byte first; out_last = (index == OUT_BYTES-1).
  - out_data and out_last are held stable while out_valid & !out_ready.
  - Each accepted byte increments the index. Acceptance of the last byte -> DONE.
- DONE:
  - done=1 for one cycle, out_valid=0.
  - -> IDLE. start in the DONE cycle is ignored.
- abort=1 in any state other than IDLE:
  - Next state IDLE, with mac_clr=1 on the following cycle.
  - Counters cleared; out_valid, mac_en and done forced to 0 that next cycle; no done pulse.
  - abort has priority over start and over handshakes in the same cycle.
- Reset asserted mid-operation: immediate return to reset values. Any partially drained result is discarded.
- No overflow handling in this block; ACC_W is sized by the MAC unit.
- Latency, zero stall, all ready signals tied high: start at cycle 0 -> first in_ready at cycle 2 -> last handshake at cycle COUNT+1 -> first out_valid at cycle COUNT+4.

Test Plan:
1. COUNT=8, eight pairs (3,3) back-to-back, out_ready=1, bench MAC model -> bytes 0x48, 0x00, 0x00; out_last on the third byte; done one cycle later; first out_valid 12 cycles after start.
2. Eight pairs (255,255) -> acc 520200 = 0x7F008 -> bytes 0x08, 0xF0, 0x07; mac_en high exactly 8 cycles; mac_clr high exactly once.
3. in_valid toggling 1,0,0,1,... with pairs (1,2)..(8,9) -> acc 240 -> bytes 0xF0, 0x00, 0x00; mac_en pulses one cycle after each handshake only.
4. out_ready low for 5 cycles on each byte -> out_data/out_last stable while stalled; no byte skipped or duplicated; busy high throughout.
5. abort after 4 of 8 pairs, then start with 8 pairs of (1,1) -> no output or done from the aborted job; mac_clr pulses after the abort; second job result 0x08, 0x00, 0x00. start pulsed while busy -> ignored.
6. rst_n low during DRAIN byte 1 -> all outputs 0 asynchronously; after release in_ready=0 until start; the next job completes normally.
